// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: job sequencer for an N x N systolic PE array.
// A job loads N weight rows, streams k_len activation vectors, then drains the
// skewed pipeline, flagging each column-0 result as it leaves the array.
module pe_array_ctrl #(
   parameter int N  = 4,
   parameter int KW = 8,
   localparam int RW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          start,
   input  logic [KW-1:0] k_len,
   input  logic          w_valid,
   output logic          w_rd,
   output logic [RW-1:0] w_row,
   input  logic          a_valid,
   output logic          a_rd,
   output logic [KW-1:0] a_idx,
   output logic          EN,
   output logic          W_EN,
   output logic          SELECTOR,
   output logic          out_valid,
   output logic [KW-1:0] out_idx,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DONE} state_t;

   // Tick offsets are held in KW+1 bits so the last tick of a maximum-length
   // job (k_len = 2^KW-1 plus the drain) never wraps.
   localparam logic [KW:0]   DRAIN_TICKS = (KW+1)'(2*N - 3);
   localparam logic [KW:0]   FIRST_OUT   = (KW+1)'(N - 1);
   localparam logic [KW:0]   OUT_SPAN    = (KW+1)'(N - 2);
   localparam logic [RW-1:0] LAST_ROW    = RW'(N - 1);

   state_t        state;
   logic [KW-1:0] k_q;
   logic [RW-1:0] row_q;
   logic [KW-1:0] aidx_q;
   logic [KW:0]   t_q;

   logic          feed;
   logic [KW:0]   t_last;
   logic [KW:0]   out_last;

   // Feed phase lasts until every vector has been accepted; after that the
   // array free-runs to flush the skew.
   assign feed     = (state == COMPUTE) && (aidx_q != k_q);
   assign t_last   = {1'b0, k_q} + DRAIN_TICKS;
   assign out_last = {1'b0, k_q} + OUT_SPAN;

   // Shared array control lines: valid-gated during feed/load, no start path.
   always_comb begin
      w_rd      = 1'b0;
      W_EN      = 1'b0;
      a_rd      = 1'b0;
      EN        = 1'b0;
      out_valid = 1'b0;
      if (state == LOAD_W) begin
         w_rd = w_valid;
         W_EN = w_valid;
      end
      if (state == COMPUTE) begin
         a_rd      = feed && a_valid;
         EN        = feed ? a_valid : 1'b1;
         out_valid = EN && (t_q >= FIRST_OUT) && (t_q <= out_last);
      end
   end

   // Register-only decodes; indices read zero outside the phase that owns them.
   assign SELECTOR = (state == LOAD_W);
   assign busy     = (state == LOAD_W) || (state == COMPUTE);
   assign done     = (state == DONE);
   assign w_row    = (state == LOAD_W)  ? row_q  : '0;
   assign a_idx    = (state == COMPUTE) ? aidx_q : '0;
   assign out_idx  = (state == COMPUTE) ? KW'(t_q - FIRST_OUT) : '0;

   // Job FSM and its row / vector / tick counters.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state  <= IDLE;
         k_q    <= '0;
         row_q  <= '0;
         aidx_q <= '0;
         t_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start && (k_len != '0)) begin
                  k_q    <= k_len;
                  row_q  <= '0;
                  aidx_q <= '0;
                  t_q    <= '0;
                  state  <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (w_valid) begin
                  if (row_q == LAST_ROW) begin
                     row_q <= '0;
                     state <= COMPUTE;
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end
            end
            COMPUTE: begin
               if (EN) begin
                  t_q <= t_q + (KW+1)'(1);
                  if (feed) aidx_q <= aidx_q + KW'(1);
                  if (t_q == t_last) state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: directed jobs from the test plan plus random-stall
// jobs, checked against a count-based job model and an end-of-job scoreboard.
module tb_pe_array_ctrl;
   localparam int N  = 4;
   localparam int KW = 8;
   localparam int RW = $clog2(N);

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic          w_valid = 1'b0;
   logic          a_valid = 1'b0;
   logic          w_rd, a_rd, EN, W_EN, SELECTOR, out_valid, busy, done;
   logic [RW-1:0] w_row;
   logic [KW-1:0] a_idx, out_idx;

   int checks = 0;
   int errors = 0;

   // Job model: a job is N accepted rows, then k accepted vectors, then
   // ticks 0 .. k+2N-3, then a one-cycle done.
   bit m_busy = 0, m_done = 0;
   int m_k = 0, m_rows = 0, m_vecs = 0, m_ticks = 0;

   pe_array_ctrl #(.N(N), .KW(KW)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .k_len(k_len),
      .w_valid(w_valid), .w_rd(w_rd), .w_row(w_row),
      .a_valid(a_valid), .a_rd(a_rd), .a_idx(a_idx),
      .EN(EN), .W_EN(W_EN), .SELECTOR(SELECTOR),
      .out_valid(out_valid), .out_idx(out_idx), .busy(busy), .done(done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_outputs();
      int  e_wrd = 0, e_row = 0, e_ard = 0, e_aidx = 0, e_en = 0;
      int  e_sel = 0, e_ov = 0, e_oidx = 0, e_busy = 0, e_done = 0;
      bit  feed;
      if (m_done) begin
         e_done = 1;
      end else if (m_busy && m_rows < N) begin
         e_busy = 1; e_sel = 1;
         e_wrd  = w_valid ? 1 : 0;
         e_row  = m_rows;
      end else if (m_busy) begin
         e_busy = 1;
         feed   = (m_vecs < m_k);
         e_ard  = (feed && a_valid) ? 1 : 0;
         e_en   = feed ? (a_valid ? 1 : 0) : 1;
         e_aidx = m_vecs;
         e_ov   = (e_en == 1 && m_ticks >= N-1 && m_ticks <= m_k + N - 2) ? 1 : 0;
         e_oidx = m_ticks - (N-1);
      end
      chk("w_rd", 32'(w_rd), e_wrd);
      chk("W_EN", 32'(W_EN), e_wrd);
      chk("w_row", 32'(w_row), e_row);
      chk("SELECTOR", 32'(SELECTOR), e_sel);
      chk("a_rd", 32'(a_rd), e_ard);
      chk("a_idx", 32'(a_idx), e_aidx);
      chk("EN", 32'(EN), e_en);
      chk("out_valid", 32'(out_valid), e_ov);
      chk("busy", 32'(busy), e_busy);
      chk("done", 32'(done), e_done);
      if (e_ov == 1)  chk("out_idx", 32'(out_idx), e_oidx);
      if (e_busy == 0) chk("out_idx_idle", 32'(out_idx), 0);
   endtask

   task automatic model_clock();
      bit feed, en;
      if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (start && k_len != 0) begin
            m_busy = 1; m_k = int'(k_len);
            m_rows = 0; m_vecs = 0; m_ticks = 0;
         end
      end else if (m_rows < N) begin
         if (w_valid) m_rows++;
      end else begin
         feed = (m_vecs < m_k);
         en   = feed ? a_valid : 1'b1;
         if (en) begin
            if (m_ticks == m_k + 2*N - 3) begin
               m_busy = 0; m_done = 1;
            end
            m_ticks++;
            if (feed) m_vecs++;
         end
      end
   endtask

   task automatic cycle_io(input bit s, input logic [KW-1:0] k, input bit wv, input bit av);
      @(negedge CLK);
      start = s; k_len = k; w_valid = wv; a_valid = av;
      #1;
      check_outputs();
      model_clock();
   endtask

   // Cycle 0 presents start; w_valid is low in cycles wlo..whi, a_valid low in
   // cycle astall; mid_start pulses an extra start; rst_cyc pulses reset.
   task automatic run_job(input int k, input int wlo, input int whi, input int astall,
                          input bit rnd, input int mid_start, input int rst_cyc,
                          input int exp_done);
      int stalls = 0, done_cyc = -1, nout = 0;
      bit reset_hit = 0;
      for (int c = 0; c < 2000; c++) begin
         bit s, wv, av;
         logic [KW-1:0] kk;
         s  = (c == 0) || (c == mid_start) || (rnd && c > 0 && $urandom_range(7) == 0);
         kk = (c == 0) ? KW'(k) : KW'($urandom_range(255, 1));
         wv = rnd ? ($urandom_range(3) != 0) : !(c >= wlo && c <= whi);
         av = rnd ? ($urandom_range(3) != 0) : (c != astall);
         if (c == rst_cyc) begin
            @(negedge CLK);
            RESET = 1'b0; start = 1'b0; w_valid = wv; a_valid = av;
            #1;
            m_busy = 0; m_done = 0;
            check_outputs();
            @(negedge CLK);
            RESET = 1'b1;
            reset_hit = 1;
            break;
         end
         if (m_busy && !m_done) begin
            if (m_rows < N && !wv) stalls++;
            else if (m_rows == N && m_vecs < m_k && !av) stalls++;
         end
         cycle_io(s, kk, wv, av);
         if (done === 1'b1 && done_cyc < 0) done_cyc = c;
         if (out_valid === 1'b1) begin
            chk("out_seq", 32'(out_idx), nout);
            nout++;
         end
         if (!m_busy && !m_done && c > 0) break;
      end
      if (!reset_hit) begin
         chk("done_cycle", done_cyc, (k == 0) ? -1 : k + 3*N - 1 + stalls);
         chk("out_count", nout, k);
         if (exp_done >= 0) chk("done_plan", done_cyc, exp_done);
      end
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      #1;
      check_outputs();
      RESET = 1'b1;
      // basic run
      run_job(3, -1, -1, -1, 0, -1, -1, 14);
      // weight stall in cycles 2-3
      run_job(3, 2, 3, -1, 0, -1, -1, 16);
      // activation stall mid-feed
      run_job(3, -1, -1, 6, 0, -1, -1, 15);
      // zero-length start ignored
      run_job(0, -1, -1, -1, 0, -1, -1, -1);
      // start pulsed during compute
      run_job(3, -1, -1, -1, 0, 10, -1, 14);
      // reset during compute at t=4, then a fresh k_len=2 job
      run_job(3, -1, -1, -1, 0, -1, 9, -1);
      run_job(2, -1, -1, -1, 0, -1, -1, 13);
      // maximum length
      run_job(255, -1, -1, -1, 0, -1, -1, 266);
      // random stalls and stray starts
      repeat (20) run_job($urandom_range(20, 1), -1, -1, -1, 1, -1, -1, -1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
